// File: rtl/ff_response_checker.sv
// Online checker for a D flip-flop with enable and synchronous active-low clear.
// Tracks the expected Q with a one-cycle reference model and counts compares/failures per run.
module ff_response_checker #(
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             R,
    input  logic             en,
    input  logic             ff_D,
    input  logic             ff_E,
    input  logic             ff_R_,
    input  logic             ff_Q,
    input  logic             ff_Q_,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CHECK, S_DONE} state_t;

    localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic             r_exp, w_exp_nxt;
    logic [CNT_W-1:0] r_err, w_err_nxt;
    logic [CNT_W-1:0] r_chk, w_chk_nxt;
    logic [CNT_W-1:0] r_first, w_first_nxt;
    logic             w_fail;
    logic             w_mismatch;

    // Case-inequality so that X/Z on either ff output is reported as a failure.
    assign w_fail = (ff_Q !== r_exp) || (ff_Q_ !== ~ff_Q);

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state <= S_IDLE;
            r_exp   <= 1'b0;
            r_err   <= '0;
            r_chk   <= '0;
            r_first <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_err   <= w_err_nxt;
            r_chk   <= w_chk_nxt;
            r_first <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_err_nxt   = r_err;
        w_chk_nxt   = r_chk;
        w_first_nxt = r_first;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_SYNC;
                    w_err_nxt   = '0;
                    w_chk_nxt   = '0;
                    w_first_nxt = '0;
                end
            end
            S_SYNC: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (!ff_R_) begin
                    w_exp_nxt   = 1'b0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_mismatch = w_fail;
                w_chk_nxt  = r_chk + ONE;
                w_exp_nxt  = !ff_R_ ? 1'b0 : (ff_E ? ff_D : r_exp);
                if (w_fail) begin
                    if (r_err == '0) w_first_nxt = r_chk + ONE;
                    if (r_err != '1) w_err_nxt = r_err + ONE;
                end
                // The compare on the exit edge is always counted before leaving.
                if ((w_chk_nxt == WIN) || !en || (STOP_ON_ERR && w_fail))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!en) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mismatch  = w_mismatch;
    assign err_cnt   = r_err;
    assign chk_cnt   = r_chk;
    assign first_err = r_first;
    assign busy      = (r_state == S_SYNC) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_err == '0) && (r_chk == WIN);

endmodule

// File: tb/tb_ff_response_checker.sv
// Directed bench: a table of single-cycle vectors with hand-computed results, plus
// hand-written sequences for stop-on-error, early stop, SYNC abort and async reset.
module tb_ff_response_checker;

    logic        clk = 1'b0;
    logic        R;
    logic        en_a, en_s;
    logic        ff_D, ff_E, ff_R_, ff_Q, ff_Q_;
    logic        mm_a, busy_a, done_a, pass_a;
    logic [15:0] err_a, chk_a, first_a;
    logic        mm_s, busy_s, done_s, pass_s;
    logic [15:0] err_s, chk_s, first_s;
    logic        ideal_q;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    ff_response_checker #(.WINDOW(8), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .R(R), .en(en_a), .ff_D(ff_D), .ff_E(ff_E), .ff_R_(ff_R_),
        .ff_Q(ff_Q), .ff_Q_(ff_Q_), .mismatch(mm_a), .err_cnt(err_a), .chk_cnt(chk_a),
        .first_err(first_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    ff_response_checker #(.WINDOW(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut_s (
        .clk(clk), .R(R), .en(en_s), .ff_D(ff_D), .ff_E(ff_E), .ff_R_(ff_R_),
        .ff_Q(ff_Q), .ff_Q_(ff_Q_), .mismatch(mm_s), .err_cnt(err_s), .chk_cnt(chk_s),
        .first_err(first_s), .busy(busy_s), .done(done_s), .pass(pass_s)
    );

    typedef struct {
        logic en, rn, d, e, qf;
        logic mm, busy, done, pass;
        int   err, chk, first;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, rn, d, e, qf, mm, bs, dn, ps, input int er, ck, fe);
        vec_t v;
        v.en = en; v.rn = rn; v.d = d; v.e = e; v.qf = qf;
        v.mm = mm; v.busy = bs; v.done = dn; v.pass = ps;
        v.err = er; v.chk = ck; v.first = fe;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // Present stimulus plus the ideal ff outputs (optionally corrupted) away from the edge.
    task automatic drive(input logic ea, es, rn, d, e, qf, qbf);
        @(negedge clk);
        en_a  = ea;
        en_s  = es;
        ff_R_ = rn;
        ff_D  = d;
        ff_E  = e;
        ff_Q  = ideal_q ^ qf;
        ff_Q_ = qbf ? (ideal_q ^ qf) : ~(ideal_q ^ qf);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        ideal_q = !ff_R_ ? 1'b0 : (ff_E ? ff_D : ideal_q);
        #1;
    endtask

    initial begin
        R = 1'b1; en_a = 1'b0; en_s = 1'b0;
        ff_R_ = 1'b1; ff_D = 1'b0; ff_E = 1'b0; ff_Q = 1'b0; ff_Q_ = 1'b1;
        ideal_q = 1'b0;
        #1;
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset chk", chk_a, 0);
        @(negedge clk);
        R = 1'b0;

        //   en rn d  e  qf | mm bsy dn ps err chk first
        // Clean WINDOW=8 run, then hold in DONE, then back to IDLE.
        add(1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0,  0, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 2, 0);
        add(1, 1, 0, 1, 0,  0, 1, 0, 0, 0, 3, 0);
        add(1, 1, 1, 0, 0,  0, 1, 0, 0, 0, 4, 0);
        add(1, 1, 1, 1, 0,  0, 1, 0, 0, 0, 5, 0);
        add(1, 0, 1, 1, 0,  0, 1, 0, 0, 0, 6, 0);
        add(1, 1, 0, 1, 0,  0, 1, 0, 0, 0, 7, 0);
        add(1, 1, 1, 1, 0,  0, 0, 1, 1, 0, 8, 0);
        add(1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 8, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 8, 0);
        // Hold with D toggling, clear beats enable, then Q inverted on compare 3.
        add(1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0,  0, 1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1, 0,  0, 1, 0, 0, 0, 2, 0);
        add(1, 1, 0, 0, 1,  1, 1, 0, 0, 1, 3, 3);
        add(1, 1, 1, 0, 0,  0, 1, 0, 0, 1, 4, 3);
        add(1, 1, 0, 0, 0,  0, 1, 0, 0, 1, 5, 3);
        add(1, 1, 1, 1, 0,  0, 1, 0, 0, 1, 6, 3);
        add(1, 1, 1, 0, 0,  0, 1, 0, 0, 1, 7, 3);
        add(1, 1, 0, 0, 0,  0, 0, 1, 0, 1, 8, 3);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 8, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, 1'b0, tbl[i].rn, tbl[i].d, tbl[i].e, tbl[i].qf, 1'b0);
            check($sformatf("v%0d mismatch", i), mm_a, tbl[i].mm);
            tick();
            check($sformatf("v%0d busy", i), busy_a, tbl[i].busy);
            check($sformatf("v%0d done", i), done_a, tbl[i].done);
            check($sformatf("v%0d pass", i), pass_a, tbl[i].pass);
            check($sformatf("v%0d err_cnt", i), err_a, tbl[i].err);
            check($sformatf("v%0d chk_cnt", i), chk_a, tbl[i].chk);
            check($sformatf("v%0d first_err", i), first_a, tbl[i].first);
        end
        check("stop dut idle during table", busy_s, 0);

        // Complement fault on compare 3, both checkers armed together.
        drive(1, 1, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 1, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 0, 1);
        check("cmpl mismatch a", mm_a, 1);
        check("cmpl mismatch s", mm_s, 1);
        tick();
        check("cmpl err a", err_a, 1);
        check("cmpl chk a", chk_a, 3);
        check("cmpl busy a", busy_a, 1);
        check("cmpl mismatch a post", mm_a, 1);
        check("stop done s", done_s, 1);
        check("stop busy s", busy_s, 0);
        check("stop chk s", chk_s, 3);
        check("stop err s", err_s, 1);
        check("stop first s", first_s, 3);
        check("stop pass s", pass_s, 0);
        check("stop mismatch s in DONE", mm_s, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 0, 0, 0, 0); tick();
        end
        check("stop no restart done", done_s, 1);
        check("stop no restart chk", chk_s, 3);
        check("cmpl chk a after 6", chk_a, 6);
        drive(0, 0, 1, 0, 0, 0, 0); tick();
        check("en drop a done", done_a, 1);
        check("en drop a chk", chk_a, 7);
        check("en drop a pass", pass_a, 0);
        check("stop s idle", done_s, 0);
        drive(0, 0, 1, 0, 0, 0, 0); tick();
        check("a back idle", done_a, 0);

        // Clean early stop: en sampled low on the edge of compare 5.
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, k[0], 0, 0, 0); tick();
        end
        drive(0, 0, 1, 1, 0, 0, 0); tick();
        check("early done", done_a, 1);
        check("early chk", chk_a, 5);
        check("early err", err_a, 0);
        check("early pass", pass_a, 0);
        drive(0, 0, 1, 0, 0, 0, 0); tick();
        check("early idle done", done_a, 0);
        check("early idle busy", busy_a, 0);
        check("early idle chk held", chk_a, 5);

        // SYNC abandoned before ff_R_ low is seen.
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        check("sync busy", busy_a, 1);
        check("sync cleared chk", chk_a, 0);
        drive(0, 0, 1, 0, 0, 0, 0); tick();
        check("sync abort busy", busy_a, 0);
        check("sync abort done", done_a, 0);

        // Async reset between edges in CHECK with a failure pending.
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 1, 0); tick();
        check("pre-rst err", err_a, 1);
        check("pre-rst first", first_a, 2);
        drive(1, 0, 1, 0, 0, 1, 0);
        check("pre-rst mismatch", mm_a, 1);
        #2;
        R = 1'b1;
        en_a = 1'b0;
        #1;
        check("rst mismatch", mm_a, 0);
        check("rst busy", busy_a, 0);
        check("rst done", done_a, 0);
        check("rst pass", pass_a, 0);
        check("rst err", err_a, 0);
        check("rst chk", chk_a, 0);
        check("rst first", first_a, 0);
        tick();
        @(negedge clk);
        R = 1'b0;
        tick();
        tick();
        check("post-rst busy", busy_a, 0);
        check("post-rst done", done_a, 0);
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        check("post-rst arm", busy_a, 1);
        drive(0, 0, 1, 0, 0, 0, 0); tick();
        check("post-rst disarm", busy_a, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
